// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC-tagged circular queue
// Fetches over req/ack, stops on halt word 16'hFFFF, restarts on redirect.
module fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic                     clock,
   input  logic                     reset,
   output logic                     imem_req,
   output logic [15:0]              imem_addr,
   input  logic                     imem_ack,
   input  logic [15:0]              imem_rdata,
   input  logic                     redirect,
   input  logic [15:0]              redirect_pc,
   output logic                     instr_valid,
   output logic [15:0]              instr,
   output logic [15:0]              instr_pc,
   input  logic                     instr_ready,
   output logic                     halted,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [15:0]      HALT_WORD  = 16'hFFFF;

   typedef enum logic {
      FETCH = 1'b0,
      HALT  = 1'b1
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [15:0]        fetch_pc;
   logic [31:0]        queue [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               push;
   logic               pop;
   logic               halt_hit;

   // The full check uses count before any same-cycle pop, so a full queue
   // being drained takes one bubble cycle before the next request.
   assign imem_req  = !reset && !redirect && (state == FETCH) && (count < FULL_COUNT);
   assign imem_addr = fetch_pc;
   assign push      = imem_req && imem_ack;
   assign pop       = instr_valid && instr_ready && !redirect;
   assign halt_hit  = push && (imem_rdata == HALT_WORD);

   assign instr_valid = (count != '0);
   assign instr       = instr_valid ? queue[rd_ptr][15:0]  : 16'h0000;
   assign instr_pc    = instr_valid ? queue[rd_ptr][31:16] : 16'h0000;
   assign halted      = (state == HALT);
   assign occupancy   = count;

   always_comb begin
      state_next = state;
      if (redirect) begin
         state_next = FETCH;
      end else if (halt_hit) begin
         state_next = HALT;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc <= RESET_PC & 16'hFFFE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else if (redirect) begin
         fetch_pc <= redirect_pc & 16'hFFFE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (!halt_hit) begin
               fetch_pc <= fetch_pc + 16'd2;
            end
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // Storage needs no reset: entries are only visible while count covers them.
   always_ff @(posedge clock) begin
      if (push) begin
         queue[wr_ptr] <= {fetch_pc, imem_rdata};
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
// Instruction memory model: word k holds 16'h7100+k, optional halt word.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        instr_valid;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_ready;
   logic        halted;
   logic [2:0]  occupancy;

   logic        halt_en;
   logic [15:0] halt_addr;
   int          n_checks = 0;
   int          n_fail   = 0;

   fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
      .clock       (clock),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .halted      (halted),
      .occupancy   (occupancy)
   );

   always #5 clock = ~clock;

   always_comb begin
      imem_rdata = 16'h7100 + {1'b0, imem_addr[15:1]};
      if (halt_en && (imem_addr == halt_addr)) imem_rdata = 16'hFFFF;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000;
      imem_ack = 1'b0; instr_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000;
      imem_ack = 1'b0; instr_ready = 1'b0; halt_en = 1'b0; halt_addr = 16'h0;
      tick();
      tick();
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
      n_checks++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
      n_checks++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h want 0000", instr); end
      n_checks++; if (instr_pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", instr_pc); end
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
      n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
      reset = 1'b0;
      #1;
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_release_req: got %b want 1", imem_req); end
   endtask

   task automatic test_zero_wait();
      do_reset();
      imem_ack = 1'b1; instr_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         n_checks++; if (imem_addr !== 16'(2*k)) begin n_fail++; $display("FAIL zw_addr%0d: got %h want %h", k, imem_addr, 16'(2*k)); end
         n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL zw_req%0d: got %b want 1", k, imem_req); end
         tick();
         n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid%0d: got %b want 1", k, instr_valid); end
         n_checks++; if (instr_pc !== 16'(2*k)) begin n_fail++; $display("FAIL zw_pc%0d: got %h want %h", k, instr_pc, 16'(2*k)); end
         n_checks++; if (instr !== 16'(16'h7100 + k)) begin n_fail++; $display("FAIL zw_instr%0d: got %h want %h", k, instr, 16'(16'h7100 + k)); end
      end
      imem_ack = 1'b0; instr_ready = 1'b0;
   endtask

   task automatic test_wait_states();
      do_reset();
      imem_ack = 1'b1; instr_ready = 1'b1;
      tick();
      imem_ack = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (imem_addr !== 16'h0002) begin n_fail++; $display("FAIL ws_addr%0d: got %h want 0002", i, imem_addr); end
         n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL ws_req%0d: got %b want 1", i, imem_req); end
         n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL ws_occ%0d: got %0d want 0", i, occupancy); end
         if (i == 3) imem_ack = 1'b1;
         tick();
      end
      imem_ack = 1'b0; instr_ready = 1'b0;
      n_checks++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL ws_occ_final: got %0d want 1", occupancy); end
      n_checks++; if (instr_pc !== 16'h0002) begin n_fail++; $display("FAIL ws_pc: got %h want 0002", instr_pc); end
      n_checks++; if (instr !== 16'h7101) begin n_fail++; $display("FAIL ws_instr: got %h want 7101", instr); end
      tick();
      n_checks++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL ws_single_push: got %0d want 1", occupancy); end
   endtask

   task automatic test_full();
      do_reset();
      imem_ack = 1'b1; instr_ready = 1'b0;
      repeat (4) tick();
      n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL full_occ: got %0d want 4", occupancy); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL full_req: got %b want 0", imem_req); end
      n_checks++; if (imem_addr !== 16'h0008) begin n_fail++; $display("FAIL full_addr: got %h want 0008", imem_addr); end
      n_checks++; if (instr_pc !== 16'h0000) begin n_fail++; $display("FAIL full_head: got %h want 0000", instr_pc); end
      instr_ready = 1'b1;
      #1;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL full_pop_req: got %b want 0", imem_req); end
      tick();
      instr_ready = 1'b0;
      n_checks++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL bubble_occ: got %0d want 3", occupancy); end
      n_checks++; if (instr_pc !== 16'h0002) begin n_fail++; $display("FAIL bubble_head: got %h want 0002", instr_pc); end
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL bubble_req: got %b want 1", imem_req); end
      n_checks++; if (imem_addr !== 16'h0008) begin n_fail++; $display("FAIL bubble_addr: got %h want 0008", imem_addr); end
      tick();
      imem_ack = 1'b0;
      n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL refill_occ: got %0d want 4", occupancy); end
      n_checks++; if (imem_addr !== 16'h000A) begin n_fail++; $display("FAIL refill_addr: got %h want 000a", imem_addr); end
   endtask

   task automatic test_halt();
      halt_en = 1'b1; halt_addr = 16'h0006;
      do_reset();
      imem_ack = 1'b1; instr_ready = 1'b0;
      repeat (4) tick();
      n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b want 1", halted); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_req: got %b want 0", imem_req); end
      n_checks++; if (imem_addr !== 16'h0006) begin n_fail++; $display("FAIL halt_addr: got %h want 0006", imem_addr); end
      instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid%0d: got %b want 1", i, instr_valid); end
         n_checks++; if (instr_pc !== 16'(2*i)) begin n_fail++; $display("FAIL drain_pc%0d: got %h want %h", i, instr_pc, 16'(2*i)); end
         n_checks++; if (instr !== ((i == 3) ? 16'hFFFF : 16'(16'h7100 + i))) begin n_fail++; $display("FAIL drain_instr%0d: got %h want %h", i, instr, ((i == 3) ? 16'hFFFF : 16'(16'h7100 + i))); end
         tick();
      end
      n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL drain_occ: got %0d want 0", occupancy); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", instr_valid); end
      n_checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_hold: got halted=%b req=%b want 1/0", halted, imem_req); end
      imem_ack = 1'b0; instr_ready = 1'b0;
      halt_en = 1'b0;
   endtask

   task automatic test_redirect();
      do_reset();
      imem_ack = 1'b1; instr_ready = 1'b0;
      repeat (3) tick();
      imem_ack = 1'b0;
      tick();
      n_checks++; if (occupancy !== 3'd3 || imem_req !== 1'b1) begin n_fail++; $display("FAIL rd_setup: got occ=%0d req=%b want 3/1", occupancy, imem_req); end
      redirect = 1'b1; redirect_pc = 16'h0041; imem_ack = 1'b1; instr_ready = 1'b1;
      #1;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rd_cycle_req: got %b want 0", imem_req); end
      tick();
      redirect = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
      #1;
      n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rd_occ: got %0d want 0", occupancy); end
      n_checks++; if (imem_addr !== 16'h0040) begin n_fail++; $display("FAIL rd_addr: got %h want 0040", imem_addr); end
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rd_req: got %b want 1", imem_req); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid: got %b want 0", instr_valid); end
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      n_checks++; if (instr_pc !== 16'h0040) begin n_fail++; $display("FAIL rd_first_pc: got %h want 0040", instr_pc); end
      n_checks++; if (instr !== 16'h7120) begin n_fail++; $display("FAIL rd_first_instr: got %h want 7120", instr); end
      n_checks++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL rd_first_occ: got %0d want 1", occupancy); end
   endtask

   task automatic test_halt_redirect();
      halt_en = 1'b1; halt_addr = 16'h0006;
      do_reset();
      imem_ack = 1'b1; instr_ready = 1'b1;
      repeat (6) tick();
      n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL hr_halted: got %b want 1", halted); end
      redirect = 1'b1; redirect_pc = 16'h0100; imem_ack = 1'b0;
      tick();
      redirect = 1'b0;
      #1;
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL hr_resume: got %b want 0", halted); end
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin n_fail++; $display("FAIL hr_fetch: got req=%b addr=%h want 1/0100", imem_req, imem_addr); end
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      n_checks++; if (instr_pc !== 16'h0100 || instr !== 16'h7180) begin n_fail++; $display("FAIL hr_instr: got pc=%h instr=%h want 0100/7180", instr_pc, instr); end
      instr_ready = 1'b0;
      halt_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      imem_ack = 1'b1; instr_ready = 1'b0;
      repeat (3) tick();
      n_checks++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL rm_setup: got %0d want 3", occupancy); end
      reset = 1'b1;
      #1;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_req_in_reset: got %b want 0", imem_req); end
      tick();
      reset = 1'b0; imem_ack = 1'b0;
      #1;
      n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rm_occ: got %0d want 0", occupancy); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b want 0", instr_valid); end
      n_checks++; if (imem_addr !== 16'h0000 || imem_req !== 1'b1) begin n_fail++; $display("FAIL rm_restart: got addr=%h req=%b want 0000/1", imem_addr, imem_req); end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_full();
      test_halt();
      test_redirect();
      test_halt_redirect();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
